// File: rtl/core_sequencer_if.sv
// Handshake bundle between the sequencer, the opcode decoder and the two memory ports.
// The master side is the sequencer; the slave side is the memories, decoder and halt source.
interface core_sequencer_if;
  logic       halt_i;
  logic       instr_req_o;
  logic       instr_gnt_i;
  logic       instr_rvalid_i;
  logic       memrd_i;
  logic       memw_i;
  logic       regwrite_i;
  logic       data_req_o;
  logic       data_we_o;
  logic       data_gnt_i;
  logic       data_rvalid_i;
  logic       ir_en_o;
  logic       pc_en_o;
  logic       rf_we_o;
  logic       err_o;
  logic [2:0] state_o;

  modport master (
    input  halt_i, instr_gnt_i, instr_rvalid_i, memrd_i, memw_i, regwrite_i,
           data_gnt_i, data_rvalid_i,
    output instr_req_o, data_req_o, data_we_o, ir_en_o, pc_en_o, rf_we_o,
           err_o, state_o
  );

  modport slave (
    output halt_i, instr_gnt_i, instr_rvalid_i, memrd_i, memw_i, regwrite_i,
           data_gnt_i, data_rvalid_i,
    input  instr_req_o, data_req_o, data_we_o, ir_en_o, pc_en_o, rf_we_o,
           err_o, state_o
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: fetch, execute, optional memory access and writeback per instruction,
// with a per-state handshake timeout and a sticky error state left only through reset.
module core_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  core_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT_I = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WAIT_D = 3'd5,
    S_WB     = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam int            CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST_CNT = TMO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_memw;
  logic          r_regwrite;
  logic          r_instr_req;
  logic          r_data_req;
  logic          r_data_we;
  logic          r_pc_en;
  logic          r_rf_we;
  logic          r_err;

  state_t w_next;
  logic   w_handshake;
  logic   w_timeout;
  logic   w_memw_eff;
  logic   w_regwrite_eff;
  logic   w_ir_en;

  always_comb begin
    w_handshake = (r_state == S_FETCH) || (r_state == S_WAIT_I) ||
                  (r_state == S_MEM)   || (r_state == S_WAIT_D);
    // r_cnt counts completed cycles in this state, so LAST_CNT marks the final allowed one.
    w_timeout   = TMO_EN && w_handshake && (r_cnt == LAST_CNT);
    w_next      = r_state;
    case (r_state)
      S_IDLE:   if (!bus.halt_i) w_next = S_FETCH;
      S_FETCH:  if (bus.instr_gnt_i) w_next = bus.instr_rvalid_i ? S_EXEC : S_WAIT_I;
                else if (w_timeout) w_next = S_ERR;
      S_WAIT_I: if (bus.instr_rvalid_i) w_next = S_EXEC;
                else if (w_timeout) w_next = S_ERR;
      S_EXEC:   if (bus.memrd_i && bus.memw_i) w_next = S_ERR;
                else if (bus.memrd_i || bus.memw_i) w_next = S_MEM;
                else w_next = S_WB;
      S_MEM:    if (bus.data_gnt_i) w_next = bus.data_rvalid_i ? S_WB : S_WAIT_D;
                else if (w_timeout) w_next = S_ERR;
      S_WAIT_D: if (bus.data_rvalid_i) w_next = S_WB;
                else if (w_timeout) w_next = S_ERR;
      S_WB:     w_next = bus.halt_i ? S_IDLE : S_FETCH;
      default:  w_next = S_ERR;
    endcase
  end

  // Outputs are registered from the next state, so flags captured this edge must be used live.
  assign w_memw_eff     = (r_state == S_EXEC) ? bus.memw_i     : r_memw;
  assign w_regwrite_eff = (r_state == S_EXEC) ? bus.regwrite_i : r_regwrite;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_memw      <= 1'b0;
      r_regwrite  <= 1'b0;
      r_instr_req <= 1'b0;
      r_data_req  <= 1'b0;
      r_data_we   <= 1'b0;
      r_pc_en     <= 1'b0;
      r_rf_we     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_handshake)  r_cnt <= r_cnt + 1'b1;
      if (r_state == S_EXEC) begin
        r_memw     <= bus.memw_i;
        r_regwrite <= bus.regwrite_i;
      end
      r_instr_req <= (w_next == S_FETCH);
      r_data_req  <= (w_next == S_MEM);
      r_data_we   <= (w_next == S_MEM) && w_memw_eff;
      r_pc_en     <= (w_next == S_WB);
      r_rf_we     <= (w_next == S_WB) && w_regwrite_eff;
      r_err       <= (w_next == S_ERR);
    end
  end

  assign w_ir_en = ((r_state == S_FETCH) && bus.instr_gnt_i && bus.instr_rvalid_i) ||
                   ((r_state == S_WAIT_I) && bus.instr_rvalid_i);

  assign bus.instr_req_o = r_instr_req;
  assign bus.data_req_o  = r_data_req;
  assign bus.data_we_o   = r_data_we;
  assign bus.ir_en_o     = w_ir_en;
  assign bus.pc_en_o     = r_pc_en;
  assign bus.rf_we_o     = r_rf_we;
  assign bus.err_o       = r_err;
  assign bus.state_o     = r_state;
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: table-driven and randomized instructions against a cycle-count
// model, plus hand sequences for halt, timeout, illegal decode and reset during WAIT_D.
module tb_core_sequencer;
  logic clk_i = 1'b0;
  logic rst_ni;

  core_sequencer_if bus();

  core_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.master)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int gd;      // fetch cycles before grant
    int rd;      // cycles from fetch grant to rvalid
    int dgd;     // memory cycles before grant
    int drd;     // cycles from data grant to rvalid
    bit mrd;
    bit mw;
    bit rw;
    int exp_cyc; // FETCH through WB inclusive
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int outs_now();
    return int'({bus.instr_req_o, bus.data_req_o, bus.data_we_o, bus.ir_en_o,
                 bus.pc_en_o, bus.rf_we_o, bus.err_o});
  endfunction

  // Instruction latency from the handshake delays alone.
  function automatic int model_cycles(input vec_t v);
    int c;
    c = (v.gd + 1 + v.rd) + 1 + 1;
    if (v.mrd || v.mw) c += v.dgd + 1 + v.drd;
    return c;
  endfunction

  task automatic clear_bus_inputs();
    bus.instr_gnt_i    = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.data_gnt_i     = 1'b0;
    bus.data_rvalid_i  = 1'b0;
    bus.memrd_i        = 1'b0;
    bus.memw_i         = 1'b0;
    bus.regwrite_i     = 1'b0;
  endtask

  // Called #1 after the edge that enters FETCH; returns #1 after the edge that leaves WB.
  task automatic run_instr(input string tag, input vec_t v);
    int cyc = 0, n_ireq = 0, n_ir = 0, n_pc = 0, n_rf = 0, n_dreq = 0, n_dwe = 0, n_e = 0;
    int iw = 0, irw = 0, dw = 0, drw = 0;
    bit ig = 0, idn = 0, dg = 0, ddn = 0, done = 0;
    int exp_dreq;
    bus.memrd_i    = v.mrd;
    bus.memw_i     = v.mw;
    bus.regwrite_i = v.rw;
    while (!done && cyc < 40) begin
      bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
      bus.data_gnt_i  = 1'b0; bus.data_rvalid_i  = 1'b0;
      if (bus.instr_req_o && !ig) begin
        if (iw == v.gd) begin
          bus.instr_gnt_i = 1'b1; ig = 1;
          if (v.rd == 0) begin bus.instr_rvalid_i = 1'b1; idn = 1; end
        end else iw++;
      end else if (ig && !idn) begin
        irw++;
        if (irw == v.rd) begin bus.instr_rvalid_i = 1'b1; idn = 1; end
      end
      if (bus.data_req_o && !dg) begin
        if (dw == v.dgd) begin
          bus.data_gnt_i = 1'b1; dg = 1;
          if (v.drd == 0) begin bus.data_rvalid_i = 1'b1; ddn = 1; end
        end else dw++;
      end else if (dg && !ddn) begin
        drw++;
        if (drw == v.drd) begin bus.data_rvalid_i = 1'b1; ddn = 1; end
      end
      #1;
      cyc++;
      n_ireq += int'(bus.instr_req_o);
      n_ir   += int'(bus.ir_en_o);
      n_pc   += int'(bus.pc_en_o);
      n_rf   += int'(bus.rf_we_o);
      n_dreq += int'(bus.data_req_o);
      n_dwe  += int'(bus.data_we_o);
      n_e    += int'(bus.err_o);
      if (bus.pc_en_o) done = 1;
      @(posedge clk_i); #1;
    end
    bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
    bus.data_gnt_i  = 1'b0; bus.data_rvalid_i  = 1'b0;
    exp_dreq = (v.mrd || v.mw) ? v.dgd + 1 : 0;
    chk({tag, " completed"}, int'(done), 1);
    chk({tag, " cycles"}, cyc, v.exp_cyc);
    chk({tag, " instr_req cycles"}, n_ireq, v.gd + 1);
    chk({tag, " ir_en pulses"}, n_ir, 1);
    chk({tag, " pc_en pulses"}, n_pc, 1);
    chk({tag, " rf_we pulses"}, n_rf, int'(v.rw));
    chk({tag, " data_req cycles"}, n_dreq, exp_dreq);
    chk({tag, " data_we cycles"}, n_dwe, v.mw ? exp_dreq : 0);
    chk({tag, " err_o"}, n_e, 0);
  endtask

  initial begin
    int n_bad;
    tbl[0] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 3};   // R-type, zero wait
    tbl[1] = '{0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 4};   // load, zero wait
    tbl[2] = '{0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 4};   // store, zero wait
    tbl[3] = '{2, 3, 1, 4, 1'b1, 1'b0, 1'b1, 14};  // load with wait states
    tbl[4] = '{2, 3, 1, 4, 1'b0, 1'b1, 1'b0, 14};  // store with wait states
    tbl[5] = '{3, 0, 0, 0, 1'b0, 1'b0, 1'b0, 6};   // fetch grant in last allowed cycle
    tbl[6] = '{0, 4, 3, 0, 1'b1, 1'b0, 1'b1, 11};  // WAIT_I and MEM exit in last cycle
    tbl[7] = '{1, 1, 0, 2, 1'b0, 1'b0, 1'b0, 5};   // no writeback, data delays unused

    clear_bus_inputs();
    bus.halt_i = 1'b1;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset state_o", int'(bus.state_o), 0);
    chk("reset outputs", outs_now(), 0);
    rst_ni = 1'b1;

    n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      if (outs_now() != 0 || bus.state_o != 3'd0) n_bad++;
    end
    chk("halted idle cycles with activity", n_bad, 0);
    bus.halt_i = 1'b0;
    @(posedge clk_i); #1;
    chk("instr_req after halt drop", int'(bus.instr_req_o), 1);

    for (int i = 0; i < 8; i++) begin
      $display("vector %0d: gd=%0d rd=%0d dgd=%0d drd=%0d rd/wr/rw=%0d%0d%0d exp_cyc=%0d",
               i, tbl[i].gd, tbl[i].rd, tbl[i].dgd, tbl[i].drd,
               tbl[i].mrd, tbl[i].mw, tbl[i].rw, tbl[i].exp_cyc);
      run_instr($sformatf("tbl%0d", i), tbl[i]);
    end

    for (int k = 0; k < 40; k++) begin
      vec_t r;
      int   op;
      r.gd  = int'($urandom_range(0, 3));
      r.rd  = int'($urandom_range(0, 4));
      r.dgd = int'($urandom_range(0, 3));
      r.drd = int'($urandom_range(0, 4));
      op    = int'($urandom_range(0, 2));
      r.mrd = (op == 1);
      r.mw  = (op == 2);
      r.rw  = 1'($urandom_range(0, 1));
      r.exp_cyc = model_cycles(r);
      $display("random %0d: gd=%0d rd=%0d dgd=%0d drd=%0d op=%0d rw=%0d exp_cyc=%0d",
               k, r.gd, r.rd, r.dgd, r.drd, op, r.rw, r.exp_cyc);
      run_instr($sformatf("rnd%0d", k), r);
    end

    // Halt raised mid-instruction only takes effect at WB.
    bus.halt_i = 1'b1;
    run_instr("halt_inflight", tbl[1]);
    $display("halt in flight: state_o=%0d", bus.state_o);
    chk("idle after WB with halt", int'(bus.state_o), 0);
    chk("no fetch while halted", int'(bus.instr_req_o), 0);
    bus.halt_i = 1'b0;
    @(posedge clk_i); #1;
    chk("fetch after halt release", int'(bus.state_o), 1);

    // Timeout: never grant the fetch.
    clear_bus_inputs();
    n_bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.state_o != 3'd1 || bus.instr_req_o != 1'b1) n_bad++;
      @(posedge clk_i); #1;
    end
    chk("fetch held for 4 cycles", n_bad, 0);
    for (int i = 0; i < 5; i++) begin
      bus.instr_gnt_i    = 1'($urandom_range(0, 1));
      bus.instr_rvalid_i = 1'($urandom_range(0, 1));
      bus.data_gnt_i     = 1'($urandom_range(0, 1));
      bus.data_rvalid_i  = 1'($urandom_range(0, 1));
      bus.halt_i         = 1'($urandom_range(0, 1));
      #1;
      $display("timeout err cycle %0d: state_o=%0d outs=%0h", i, bus.state_o, outs_now());
      chk("timeout state ERR", int'(bus.state_o), 7);
      chk("timeout only err_o", outs_now(), 1);
      @(posedge clk_i); #1;
    end

    // Illegal decode.
    clear_bus_inputs();
    bus.halt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("async reset from ERR", int'(bus.state_o), 0);
    chk("err_o cleared by reset", int'(bus.err_o), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    bus.instr_gnt_i = 1'b1; bus.instr_rvalid_i = 1'b1;
    bus.memrd_i = 1'b1; bus.memw_i = 1'b1; bus.regwrite_i = 1'b1;
    n_bad = 0;
    #1;
    n_bad += int'(bus.data_req_o) + int'(bus.pc_en_o) + int'(bus.rf_we_o);
    @(posedge clk_i); #1;
    bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
    #1;
    chk("illegal decode reaches EXEC", int'(bus.state_o), 3);
    n_bad += int'(bus.data_req_o) + int'(bus.pc_en_o) + int'(bus.rf_we_o);
    @(posedge clk_i); #1;
    $display("illegal decode: state_o=%0d err_o=%0d", bus.state_o, bus.err_o);
    chk("illegal decode ERR", int'(bus.state_o), 7);
    chk("illegal decode err_o", int'(bus.err_o), 1);
    n_bad += int'(bus.data_req_o) + int'(bus.pc_en_o) + int'(bus.rf_we_o);
    chk("illegal decode no pulses", n_bad, 0);

    // Reset while in WAIT_D.
    clear_bus_inputs();
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    bus.instr_gnt_i = 1'b1; bus.instr_rvalid_i = 1'b1;
    bus.memrd_i = 1'b1; bus.regwrite_i = 1'b1;
    @(posedge clk_i); #1;
    bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    bus.data_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus.data_gnt_i = 1'b0;
    #1;
    chk("reached WAIT_D", int'(bus.state_o), 5);
    rst_ni = 1'b0;
    #1;
    $display("reset in WAIT_D: state_o=%0d rf_we=%0d", bus.state_o, bus.rf_we_o);
    chk("async reset in WAIT_D", int'(bus.state_o), 0);
    n_bad = 0;
    for (int i = 0; i < 2; i++) begin
      bus.data_rvalid_i = 1'b1;
      @(posedge clk_i); #1;
      n_bad += int'(bus.rf_we_o) + int'(bus.pc_en_o);
    end
    chk("no writeback for aborted load", n_bad, 0);
    clear_bus_inputs();
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("fetch resumes after reset", int'(bus.instr_req_o), 1);
    run_instr("post_reset", tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
